// File: rtl/multicycle_controller_if.sv
// rtl/multicycle_controller_if.sv - control bundle between the multicycle controller and its datapath
interface multicycle_controller_if;
   logic [19:0] Instr;
   logic [3:0]  ALUFlags;
   logic        PCWrite;
   logic        AdrSrc;
   logic        MemWrite;
   logic        IRWrite;
   logic [1:0]  ResultSrc;
   logic        ALUSrcA;
   logic [1:0]  ALUSrcB;
   logic [1:0]  ImmSrc;
   logic [1:0]  RegSrc;
   logic        RegWrite;
   logic [1:0]  ALUControl;

   modport master (
      input  Instr, ALUFlags,
      output PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc, ALUSrcA, ALUSrcB,
             ImmSrc, RegSrc, RegWrite, ALUControl
   );

   modport slave (
      output Instr, ALUFlags,
      input  PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc, ALUSrcA, ALUSrcB,
             ImmSrc, RegSrc, RegWrite, ALUControl
   );
endinterface

// File: rtl/multicycle_controller.sv
// rtl/multicycle_controller.sv - FSM sequencer and condition logic for the multicycle ARM datapath
module multicycle_controller (
   input  logic                    clk,
   input  logic                    reset,
   multicycle_controller_if.master ctl
);
   typedef enum logic [3:0] {
      FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE,
      EXECUTER, EXECUTEI, ALUWB, BRANCH
   } state_t;

   state_t     state;
   state_t     state_next;
   state_t     out_state;
   logic [3:0] flags;

   logic [3:0] cond;
   logic [1:0] op;
   logic [5:0] funct;
   logic [3:0] rd;
   logic       n, z, c, v;

   assign cond  = ctl.Instr[19:16];
   assign op    = ctl.Instr[15:14];
   assign funct = ctl.Instr[13:8];
   assign rd    = ctl.Instr[3:0];
   assign {n, z, c, v} = flags;

   logic cond_ex;
   always_comb begin
      cond_ex = 1'b1;
      case (cond)
         4'b0000: cond_ex = z;
         4'b0001: cond_ex = ~z;
         4'b0010: cond_ex = c;
         4'b0011: cond_ex = ~c;
         4'b0100: cond_ex = n;
         4'b0101: cond_ex = ~n;
         4'b0110: cond_ex = v;
         4'b0111: cond_ex = ~v;
         4'b1000: cond_ex = c & ~z;
         4'b1001: cond_ex = ~c | z;
         4'b1010: cond_ex = (n == v);
         4'b1011: cond_ex = (n != v);
         4'b1100: cond_ex = ~z & (n == v);
         4'b1101: cond_ex = z | (n != v);
         default: cond_ex = 1'b1;
      endcase
   end

   logic [1:0] alu_cmd;
   logic       add_sub;
   always_comb begin
      alu_cmd = 2'b00;
      add_sub = 1'b0;
      case (funct[4:1])
         4'b0100: begin alu_cmd = 2'b00; add_sub = 1'b1; end
         4'b0010: begin alu_cmd = 2'b01; add_sub = 1'b1; end
         4'b0000: alu_cmd = 2'b10;
         4'b1100: alu_cmd = 2'b11;
         default: alu_cmd = 2'b00;
      endcase
   end

   logic       executing;
   logic [1:0] flag_w;
   assign executing = (state == EXECUTER) || (state == EXECUTEI);
   assign flag_w    = {executing & funct[0], executing & funct[0] & add_sub};

   always_ff @(posedge clk) begin
      if (reset) begin
         state <= FETCH;
         flags <= 4'b0000;
      end else begin
         state <= state_next;
         if (cond_ex && flag_w[1]) flags[3:2] <= ctl.ALUFlags[3:2];
         if (cond_ex && flag_w[0]) flags[1:0] <= ctl.ALUFlags[1:0];
      end
   end

   // While reset is held the datapath selects mirror FETCH, whatever the state register holds.
   assign out_state = reset ? FETCH : state;

   logic       fetch, ir_write, adr_src, reg_w, mem_w, branch, alu_src_a;
   logic [1:0] result_src, alu_src_b, alu_control;
   always_comb begin
      state_next  = FETCH;
      fetch       = 1'b0;
      ir_write    = 1'b0;
      adr_src     = 1'b0;
      reg_w       = 1'b0;
      mem_w       = 1'b0;
      branch      = 1'b0;
      alu_src_a   = 1'b0;
      result_src  = 2'b00;
      alu_src_b   = 2'b00;
      alu_control = 2'b00;

      case (state)
         FETCH:    state_next = DECODE;
         DECODE: begin
            case (op)
               2'b00:   state_next = funct[5] ? EXECUTEI : EXECUTER;
               2'b01:   state_next = MEMADR;
               2'b10:   state_next = BRANCH;
               default: state_next = FETCH;
            endcase
         end
         MEMADR:   state_next = funct[0] ? MEMREAD : MEMWRITE;
         MEMREAD:  state_next = MEMWB;
         EXECUTER: state_next = ALUWB;
         EXECUTEI: state_next = ALUWB;
         default:  state_next = FETCH;
      endcase

      case (out_state)
         FETCH: begin
            fetch      = 1'b1;
            ir_write   = 1'b1;
            alu_src_a  = 1'b1;
            alu_src_b  = 2'b10;
            result_src = 2'b10;
         end
         DECODE: begin
            alu_src_a  = 1'b1;
            alu_src_b  = 2'b10;
            result_src = 2'b10;
         end
         MEMADR:   alu_src_b = 2'b01;
         MEMREAD:  adr_src = 1'b1;
         MEMWB: begin
            result_src = 2'b01;
            reg_w      = 1'b1;
         end
         MEMWRITE: begin
            adr_src = 1'b1;
            mem_w   = 1'b1;
         end
         EXECUTER: alu_control = alu_cmd;
         EXECUTEI: begin
            alu_src_b   = 2'b01;
            alu_control = alu_cmd;
         end
         ALUWB:    reg_w = 1'b1;
         BRANCH: begin
            alu_src_b  = 2'b01;
            result_src = 2'b10;
            branch     = 1'b1;
         end
         default: ;
      endcase
   end

   logic pcs;
   assign pcs = branch | (reg_w & (rd == 4'b1111));

   assign ctl.PCWrite    = ~reset & (fetch | (pcs & cond_ex));
   assign ctl.RegWrite   = ~reset & reg_w & cond_ex;
   assign ctl.MemWrite   = ~reset & mem_w & cond_ex;
   assign ctl.IRWrite    = ~reset & ir_write;
   assign ctl.AdrSrc     = adr_src;
   assign ctl.ResultSrc  = result_src;
   assign ctl.ALUSrcA    = alu_src_a;
   assign ctl.ALUSrcB    = alu_src_b;
   assign ctl.ALUControl = alu_control;
   assign ctl.ImmSrc     = op;
   assign ctl.RegSrc     = {op == 2'b01, op == 2'b10};
endmodule
